// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants, fetch FSM encoding and fetch-queue entry type
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic {RUN, FLUSH} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/gnt/rvalid bus between fetch and imem
interface fetch_unit_if;
  import rv32_pkg::*;
  logic req;
  logic [XLEN-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [XLEN-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order queue of {pc, instr} with flush taking priority over push/pop
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  function automatic logic [AW-1:0] nxt(logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop_i & (cnt_q != '0);
  always_ff @(posedge clk) begin
    if (rst | flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage; issues imem requests, queues words, handles redirects
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  output logic            misalign_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, issue_pc_q, issue_pc_d, target;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic misalign_q, pop, push, grant, rv_any;
  fetch_entry_t head, din;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign instr_valid = count != '0;
  assign pop = instr_valid & ~stall & ~redirect;
  // Words in flight plus queued words never exceed the queue depth, so a push always fits
  assign imem.req = ~rst & (state_q == RUN) & ~redirect
                  & (int'(out_q) + int'(count) - int'(pop) < FIFO_DEPTH);
  assign imem.addr = fetch_pc_q;
  assign grant = imem.req & imem.gnt;
  assign rv_any = imem.rvalid & ((out_q | drop_q) != '0);
  assign push = imem.rvalid & (drop_q == '0) & (out_q != '0);
  assign din = '{pc: issue_pc_q, instr: imem.rdata};
  always_comb begin
    fetch_pc_d = redirect ? target : grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
    issue_pc_d = redirect ? target : push ? issue_pc_q + 32'd4 : issue_pc_q;
    out_d = redirect ? '0 : out_q + CW'(grant) - CW'(push);
    drop_d = redirect ? out_q + drop_q - CW'(rv_any) : drop_q - CW'(imem.rvalid & (drop_q != '0));
    state_d = ((redirect | (state_q == FLUSH)) & (drop_d != '0)) ? FLUSH : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      misalign_q <= redirect & (redirect_pc[1:0] != 2'b00);
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .flush_i(redirect),
    .din_i(din),
    .head_o(head),
    .count_o(count)
  );
  assign instr_out = instr_valid ? head.instr : NOP_INSTR;
  assign pc_out = instr_valid ? head.pc : '0;
  assign misalign_err = misalign_q;
endmodule
